muldiv_ctrl: RTL and testbench

//  Sequences MULT/MULTU/DIV/DIVU and MTHI/MTLO issued from EXE; owns the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_div_iter.sv | 38 +++
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    WB
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MUL,
    OP_DIV,
    OP_MTHI,
    OP_MTLO
  } op_sel_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Divide-by-zero quotient; sliced down to the operand width at the use site.
  localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

  function automatic op_sel_e decode_op(input logic mul, input logic div,
                                        input logic mthi, input logic mtlo);
    if (mul) return OP_MUL;
    if (div) return OP_DIV;
    if (mthi) return OP_MTHI;
    if (mtlo) return OP_MTLO;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EXE <-> mul/div unit op handshake, operands, status and HI/LO readback.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic             op_mul;
  logic             op_div;
  logic             op_unsign;
  logic             op_mthi;
  logic             op_mtlo;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_mul, op_div, op_unsign, op_mthi, op_mtlo, src_a, src_b, cancel,
    input  op_ready, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op_mul, op_div, op_unsign, op_mthi, op_mtlo, src_a, src_b, cancel,
    output op_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_div_iter.sv
// Restoring radix-2 divide datapath on unsigned magnitudes; sequenced by muldiv_ctrl.
module muldiv_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0] trial;

  // The dividend shifts out of the quotient register MSB-first into the remainder.
  assign trial = {remainder, quotient[WIDTH-1]} - {1'b0, divisor};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= {remainder[WIDTH-2:0], quotient[WIDTH-1]};
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU and MTHI/MTLO sequencer owning HI/LO. Defining MULDIV_FAST_MUL_EN
// swaps the iterative shift-add multiplier for a 2-stage pipelined one.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] HI_RESET = '0
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int unsigned    CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam logic [CW-1:0]  MUL_LAST = CW'(1);
`else
  localparam logic [CW-1:0]  MUL_LAST = CNT_MAX;
`endif

  state_e             state;
  logic [CW-1:0]      cnt;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q, a_raw;
  logic               is_div, neg_res, neg_rem, div0;
  op_sel_e            op;
  logic               accept, sgn_a, sgn_b, cnt_last;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem, q_fix, r_fix, div_hi, div_lo;
  logic [2*WIDTH-1:0] mul_res;

  assign op           = decode_op(bus.op_mul, bus.op_div, bus.op_mthi, bus.op_mtlo);
  assign bus.op_ready = (state == IDLE) & ~bus.cancel;
  assign accept       = bus.op_valid & bus.op_ready;
  assign sgn_a        = ~bus.op_unsign & bus.src_a[WIDTH-1];
  assign sgn_b        = ~bus.op_unsign & bus.src_b[WIDTH-1];
  assign abs_a        = sgn_a ? ('0 - bus.src_a) : bus.src_a;
  assign abs_b        = sgn_b ? ('0 - bus.src_b) : bus.src_b;
  assign cnt_last     = (state == DIV) ? (cnt == CNT_MAX) : (cnt == MUL_LAST);

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && (op == OP_DIV)),
    .step     (state == DIV),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quotient (quo),
    .remainder(rem)
  );

  assign q_fix  = neg_res ? ('0 - quo) : quo;
  assign r_fix  = neg_rem ? ('0 - rem) : rem;
  assign div_hi = div0 ? a_raw : r_fix;
  assign div_lo = div0 ? DIV0_LO[WIDTH-1:0] : q_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0]   opa, opb;
  logic [2*WIDTH-1:0] p1, p2;

  // Stage 1 multiplies magnitudes, stage 2 applies the sign; both run while in MUL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa <= '0;
      opb <= '0;
      p1  <= '0;
      p2  <= '0;
    end else begin
      if (accept && (op == OP_MUL)) begin
        opa <= abs_a;
        opb <= abs_b;
      end
      if (state == MUL) begin
        p1 <= {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
        p2 <= neg_res ? ('0 - p1) : p1;
      end
    end
  end

  assign mul_res = p2;
`else
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     psum;

  // Multiplier sits in the low half and shifts out as partial sums shift into the top.
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      prod  <= '0;
    end else if (accept && (op == OP_MUL)) begin
      mcand <= abs_a;
      prod  <= {{WIDTH{1'b0}}, abs_b};
    end else if (state == MUL) begin
      prod <= {psum, prod[WIDTH-1:1]};
    end
  end

  assign mul_res = neg_res ? ('0 - prod) : prod;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= HI_RESET;
      lo_q    <= HI_RESET;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MUL, OP_DIV: begin
                state   <= (op == OP_DIV) ? DIV : MUL;
                cnt     <= '0;
                busy_q  <= 1'b1;
                is_div  <= (op == OP_DIV);
                neg_res <= sgn_a ^ sgn_b;
                neg_rem <= sgn_a;
                div0    <= (bus.src_b == '0);
                a_raw   <= bus.src_a;
              end
              OP_MTHI: hi_q <= bus.src_a;
              OP_MTLO: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (bus.cancel) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (cnt_last) state <= WB;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!bus.cancel) begin
            {hi_q, lo_q} <= is_div ? {div_hi, div_lo} : mul_res;
            done_q       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver queues expected HI/LO and completion cycle,
// a negedge monitor checks busy/op_ready/HI/LO every cycle and pops on done.
module tb_muldiv_ctrl;
  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;
  localparam int K_MUL = 0, K_DIV = 1, K_MTHI = 2, K_MTLO = 3;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  muldiv_if #(.WIDTH(W)) bus();

  muldiv_ctrl #(.WIDTH(W), .HI_RESET(32'h0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] ref_hi = '0, ref_lo = '0;
  int          busy_start = 0, busy_end = 0;
  bit          mon_en = 1'b0;
  bit          mon_busy;
  exp_t        mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
    longint sa, sb;
    if (uns) return {32'h0, a} * {32'h0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Returns {hi = remainder, lo = quotient}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (uns) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      mon_busy = (cyc >= busy_start) && (cyc < busy_end);
      chk("busy", 64'(bus.busy), 64'(mon_busy));
      chk("op_ready", 64'(bus.op_ready), 64'(!mon_busy && !bus.cancel));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'(bus.done), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.at));
          chk("wb_hi", 64'(bus.hi), 64'(mon_e.hi));
          chk("wb_lo", 64'(bus.lo), 64'(mon_e.lo));
          ref_hi = mon_e.hi;
          ref_lo = mon_e.lo;
        end
      end else begin
        chk("hold_hi", 64'(bus.hi), 64'(ref_hi));
        chk("hold_lo", 64'(bus.lo), 64'(ref_lo));
      end
    end
  end

  // Called at posedge+2; returns at the following posedge+2.
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input logic uns, input logic cxl, output logic acc);
    logic [63:0] r;
    exp_t e;
    bus.op_valid  = 1'b1;
    bus.op_mul    = (kind == K_MUL);
    bus.op_div    = (kind == K_DIV);
    bus.op_mthi   = (kind == K_MTHI);
    bus.op_mtlo   = (kind == K_MTLO);
    bus.op_unsign = uns;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.cancel    = cxl;
    #1;
    acc = bus.op_ready;
    if (acc && (kind == K_MUL || kind == K_DIV)) begin
      r    = (kind == K_MUL) ? ref_mul(a, b, uns) : ref_div(a, b, uns);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.at = cyc + 1 + ((kind == K_MUL) ? MUL_LAT : DIV_LAT);
      exp_q.push_back(e);
      busy_start = cyc + 1;
      busy_end   = e.at;
    end
    @(posedge clk); #2;
    bus.op_valid = 1'b0;
    bus.op_mul   = 1'b0;
    bus.op_div   = 1'b0;
    bus.op_mthi  = 1'b0;
    bus.op_mtlo  = 1'b0;
    bus.cancel   = 1'b0;
    if (acc && kind == K_MTHI) ref_hi = a;
    if (acc && kind == K_MTLO) ref_lo = a;
  endtask

  task automatic cancel_now();
    bus.cancel = 1'b1;
    exp_q.delete();
    busy_end = cyc + 1;
    @(posedge clk); #2;
    bus.cancel = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("idle_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input string nm);
    logic acc;
    issue(kind, a, b, uns, 1'b0, acc);
    chk(nm, 64'(acc), 64'd1);
    if (kind == K_MUL || kind == K_DIV) wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   kind;
    bus.op_valid = 1'b0; bus.op_mul = 1'b0; bus.op_div = 1'b0; bus.op_unsign = 1'b0;
    bus.op_mthi = 1'b0; bus.op_mtlo = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ready", 64'(bus.op_ready), 64'd1);
    mon_en = 1'b1;
    @(posedge clk); #2;

    run_op(K_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "acc_multu_max");
    run_op(K_MUL, 32'hFFFF_FFFE, 32'd3, 1'b0, "acc_mult_neg");
    run_op(K_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "acc_div_neg");
    run_op(K_DIV, 32'd7, 32'd2, 1'b1, "acc_divu");
    run_op(K_DIV, 32'd5, 32'd0, 1'b1, "acc_divu_zero");
    run_op(K_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, "acc_div_zero");
    run_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "acc_div_ovf");

    // Cancel ten cycles after accept, then MTLO must go straight in.
    issue(K_DIV, 32'd100, 32'd7, 1'b0, 1'b0, acc);
    chk("acc_div_cxl", 64'(acc), 64'd1);
    repeat (9) begin @(posedge clk); #2; end
    cancel_now();
    run_op(K_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0, "acc_mtlo_after_cancel");

    // Cancel during the write-back cycle.
    issue(K_DIV, 32'd1000, 32'd3, 1'b1, 1'b0, acc);
    chk("acc_div_wb_cxl", 64'(acc), 64'd1);
    repeat (DIV_LAT - 1) begin @(posedge clk); #2; end
    cancel_now();
    repeat (3) begin @(posedge clk); #2; end

    issue(K_MUL, 32'd9, 32'd9, 1'b1, 1'b1, acc);
    chk("cxl_same_cycle_mul", 64'(acc), 64'd0);
    issue(K_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, acc);
    chk("cxl_same_cycle_mthi", 64'(acc), 64'd0);

    run_op(K_MTHI, 32'h1234_5678, 32'h0, 1'b0, "acc_mthi");
    run_op(K_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0, "acc_mtlo");
    @(posedge clk); #2;

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      run_op(kind, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), "acc_rand");
    end

    // Asynchronous reset in the middle of a divide.
    issue(K_DIV, 32'h7654_3210, 32'd13, 1'b1, 1'b0, acc);
    chk("acc_div_rst", 64'(acc), 64'd1);
    repeat (5) begin @(posedge clk); #2; end
    reset = 1'b1;
    exp_q.delete();
    busy_start = 0;
    busy_end   = 0;
    ref_hi     = '0;
    ref_lo     = '0;
    #1;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_hi", 64'(bus.hi), 64'd0);
    chk("rst_mid_lo", 64'(bus.lo), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    run_op(K_DIV, 32'd50, 32'd6, 1'b1, "acc_post_rst");
    repeat (2) begin @(posedge clk); #2; end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
